// File: rtl/mealy_10010.sv
// mealy_10010 -- serial Mealy detector for the bit pattern 1-0-0-1-0 on j.
//
// w is raised combinationally while the detector sits in S4 ("1001" seen)
// and the current bit j is 0. Overlapping matches are kept: after a match
// the trailing "10" is reused as the start of the next pattern.
//
// Optional feature macro: MATCH_CNT_EN
//   When defined, adds parameter CNT_W and a saturating match counter on
//   output match_cnt. When undefined, neither the port nor the logic exists.
//   The detector itself is identical in both builds.
//
// state | meaning
// ------+------------------------------------------------
// S0    | idle, no useful prefix seen
// S1    | "1"
// S2    | "10"
// S3    | "100"
// S4    | "1001"; j=0 completes the match (w=1)
// other | illegal code, recovers to S0 with w=0

module mealy_10010
`ifdef MATCH_CNT_EN
#(
  parameter int CNT_W = 8
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
`ifdef MATCH_CNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             w
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  state_t state_q, state_d;

  // State register; reset clears any partial match without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Mealy output decode. In S4, j=0 is the match and the
  // walk goes to S2 so the shared "10" suffix seeds the next pattern.
  always_comb begin
    state_d = S0;
    w       = 1'b0;
    case (state_q)
      S0: state_d = j ? S1 : S0;
      S1: state_d = j ? S1 : S2;
      S2: state_d = j ? S1 : S3;
      S3: state_d = j ? S4 : S0;
      S4: begin
        state_d = j ? S1 : S2;
        w       = ~j;
      end
      default: begin
        state_d = S0;
        w       = 1'b0;
      end
    endcase
  end

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter increment: one per edge at which w is sampled high, holding at
  // the all-ones value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (w && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register, cleared asynchronously together with the detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mealy_10010.sv
// Directed bench for mealy_10010. Inputs change 2 ns after each rising
// edge; w is checked 1 ns later, registered state/count 2 ns after an edge.

module tb_mealy_10010;

  logic clk;
  logic rst;
  logic j;
  logic w;
`ifdef MATCH_CNT_EN
  logic [1:0] match_cnt;
`endif

  int checks;
  int failures;

`ifdef MATCH_CNT_EN
  mealy_10010 #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .j         (j),
    .match_cnt (match_cnt),
    .w         (w)
  );
`else
  mealy_10010 dut (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .w   (w)
  );
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+2: drive j, check w, advance to the next posedge+2.
  task automatic step(input logic jv, input logic exp_w, input string tag);
    j = jv;
    #1;
    chk(tag, 32'(w), 32'(exp_w));
    @(posedge clk);
    #2;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    chk(tag, 32'(dut.state_q), 32'(exp));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    j        = 1'b0;

    #5;
    chk("reset_w", 32'(w), 0);
    chk_state("reset_state", 3'b000);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Single match: 1,0,0,1 sampled at 30..90 ns, j=0 from 92 ns
    step(1'b1, 1'b0, "single_b1");
    step(1'b0, 1'b0, "single_b2");
    step(1'b0, 1'b0, "single_b3");
    step(1'b1, 1'b0, "single_b4");
    step(1'b0, 1'b1, "single_match");
    chk_state("single_state_s2", 3'b010);

    // Flush to S0 (S2 -0-> S3 -0-> S0)
    step(1'b0, 1'b0, "flush1_a");
    step(1'b0, 1'b0, "flush1_b");
    chk_state("flush1_state", 3'b000);

    // Overlap: 1,0,0,1,0,0,1,0 -> w on bits 5 and 8
    step(1'b1, 1'b0, "ovl_1");
    step(1'b0, 1'b0, "ovl_2");
    step(1'b0, 1'b0, "ovl_3");
    step(1'b1, 1'b0, "ovl_4");
    step(1'b0, 1'b1, "ovl_5_match");
    step(1'b0, 1'b0, "ovl_6");
    step(1'b1, 1'b0, "ovl_7");
    step(1'b0, 1'b1, "ovl_8_match");
    chk_state("ovl_state_s2", 3'b010);
    step(1'b0, 1'b0, "flush2_a");
    step(1'b0, 1'b0, "flush2_b");

    // Re-sync: 1,1,0,0,1,0 -> w on last bit only
    step(1'b1, 1'b0, "resync_1");
    step(1'b1, 1'b0, "resync_2");
    step(1'b0, 1'b0, "resync_3");
    step(1'b0, 1'b0, "resync_4");
    step(1'b1, 1'b0, "resync_5");
    step(1'b0, 1'b1, "resync_6_match");
    // Tail 1,0,0,1,1 -> no match, ends in S1
    step(1'b1, 1'b0, "tail_1");
    step(1'b0, 1'b0, "tail_2");
    step(1'b0, 1'b0, "tail_3");
    step(1'b1, 1'b0, "tail_4");
    step(1'b1, 1'b0, "tail_5_s4_j1");
    chk_state("tail_state_s1", 3'b001);
    step(1'b0, 1'b0, "flush3_a");
    step(1'b0, 1'b0, "flush3_b");
    step(1'b0, 1'b0, "flush3_c");
    chk_state("flush3_state", 3'b000);

    // No false match: 1,0,1,0,0,1,1,0,0,0
    step(1'b1, 1'b0, "nofalse_1");
    step(1'b0, 1'b0, "nofalse_2");
    step(1'b1, 1'b0, "nofalse_3");
    step(1'b0, 1'b0, "nofalse_4");
    step(1'b0, 1'b0, "nofalse_5");
    step(1'b1, 1'b0, "nofalse_6");
    step(1'b1, 1'b0, "nofalse_7");
    step(1'b0, 1'b0, "nofalse_8");
    step(1'b0, 1'b0, "nofalse_9");
    step(1'b0, 1'b0, "nofalse_10");
    chk_state("nofalse_state", 3'b000);

    // In S4, w follows j within the cycle; final j=1 is sampled -> S1
    step(1'b1, 1'b0, "glitch_1");
    step(1'b0, 1'b0, "glitch_2");
    step(1'b0, 1'b0, "glitch_3");
    step(1'b1, 1'b0, "glitch_4");
    j = 1'b1;
    #1;
    chk("s4_j1_w0", 32'(w), 0);
    j = 1'b0;
    #1;
    chk("s4_j0_w1", 32'(w), 1);
    j = 1'b1;
    #1;
    chk("s4_j1_again_w0", 32'(w), 0);
    @(posedge clk);
    #2;
    chk_state("glitch_state_s1", 3'b001);

    // Reset mid-pattern: reach S4, assert rst mid-cycle
    step(1'b0, 1'b0, "rstmid_1");
    step(1'b0, 1'b0, "rstmid_2");
    step(1'b1, 1'b0, "rstmid_3");
    j = 1'b0;
    #1;
    chk("rstmid_pre_w1", 32'(w), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("rstmid_w0", 32'(w), 0);
    chk_state("rstmid_state_s0", 3'b000);
    #4;
    rst = 1'b0;
    #1;
    chk("rstrel_w0", 32'(w), 0);
    @(posedge clk);
    #2;
    chk_state("rstrel_state_s0", 3'b000);
    // Old progress is gone; a full 10010 is needed again
    step(1'b0, 1'b0, "after_rst_0");
    step(1'b1, 1'b0, "after_rst_1");
    step(1'b0, 1'b0, "after_rst_2");
    step(1'b0, 1'b0, "after_rst_3");
    step(1'b1, 1'b0, "after_rst_4");
    step(1'b0, 1'b1, "after_rst_match");

`ifdef MATCH_CNT_EN
    // Counter (CNT_W=2): 5 overlapping matches -> 1,2,3,3,3; rst -> 0
    rst = 1'b1;
    #1;
    chk("cnt_rst", 32'(match_cnt), 0);
    rst = 1'b0;
    j = 1'b0;
    @(posedge clk);
    #2;
    step(1'b1, 1'b0, "cnt_a1");
    step(1'b0, 1'b0, "cnt_a2");
    step(1'b0, 1'b0, "cnt_a3");
    step(1'b1, 1'b0, "cnt_a4");
    chk("cnt_before", 32'(match_cnt), 0);
    step(1'b0, 1'b1, "cnt_m1");
    chk("cnt_1", 32'(match_cnt), 1);
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 1'b0, "cnt_x0");
      step(1'b1, 1'b0, "cnt_x1");
      step(1'b0, 1'b1, "cnt_mk");
      chk("cnt_k", 32'(match_cnt), (k < 3) ? k : 3);
    end
    rst = 1'b1;
    #1;
    chk("cnt_rst_end", 32'(match_cnt), 0);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
